// File: rtl/free_list_pkg.sv
// Shared sizing defaults for the R10K physical-register free list.
package free_list_pkg;
  localparam int FL_N          = 3;
  localparam int FL_ARCH_COUNT = 32;
  localparam int FL_PHYS_REGS  = 64;
  localparam int FL_PRW        = $clog2(FL_PHYS_REGS);
endpackage

// File: rtl/free_list_if.sv
// Rename-side bundle: allocation lanes, retire free mask, recovery source and status.
interface free_list_if
  import free_list_pkg::*;
#(
  parameter int N         = FL_N,
  parameter int PHYS_REGS = FL_PHYS_REGS,
  parameter int PRW       = $clog2(PHYS_REGS)
);
  logic [N-1:0]          allocReq;
  logic [N-1:0]          allocGrant;
  logic [N-1:0][PRW-1:0] allocTags;
  logic [PHYS_REGS-1:0]  freeMask;
  logic                  recoverEn;
  logic [PHYS_REGS-1:0]  archUsedMask;
  logic [PRW:0]          freeCount;
  logic                  emptyFlag;

  modport master (
    output allocReq, freeMask, recoverEn, archUsedMask,
    input  allocGrant, allocTags, freeCount, emptyFlag
  );
  modport slave (
    input  allocReq, freeMask, recoverEn, archUsedMask,
    output allocGrant, allocTags, freeCount, emptyFlag
  );
endinterface

// File: rtl/free_list_picker.sv
// Combinational: N lowest set-bit indices of a bitmap via cascaded priority encoders.
module free_list_picker
  import free_list_pkg::*;
#(
  parameter int N         = FL_N,
  parameter int PHYS_REGS = FL_PHYS_REGS,
  parameter int PRW       = $clog2(PHYS_REGS)
) (
  input  logic [PHYS_REGS-1:0]  bits_i,
  output logic [N-1:0]          pick_vld_o,
  output logic [N-1:0][PRW-1:0] pick_idx_o
);
  logic [PHYS_REGS-1:0] avail [N+1];

  assign avail[0] = bits_i;

  for (genvar s = 0; s < N; s++) begin : g_slot
    logic           hit;
    logic [PRW-1:0] pos;

    // Descending scan so the last match is the lowest index.
    always_comb begin
      hit = 1'b0;
      pos = '0;
      for (int i = PHYS_REGS - 1; i >= 0; i--) begin
        if (avail[s][i]) begin
          hit = 1'b1;
          pos = PRW'(i);
        end
      end
    end

    assign avail[s+1]    = hit ? (avail[s] & ~(PHYS_REGS'(1) << pos)) : avail[s];
    assign pick_vld_o[s] = hit;
    assign pick_idx_o[s] = pos;
  end
endmodule

// File: rtl/free_list.sv
// Bitmap free list: in-order multi-lane PR grant, retire reclaim, branch-recovery rebuild.
module free_list
  import free_list_pkg::*;
#(
  parameter int N          = FL_N,
  parameter int ARCH_COUNT = FL_ARCH_COUNT,
  parameter int PHYS_REGS  = FL_PHYS_REGS,
  parameter int PRW        = $clog2(PHYS_REGS)
) (
  input  logic        clock,
  input  logic        reset,
  free_list_if.slave  fl
);
  localparam logic [PHYS_REGS-1:0] RST_FREE  = {PHYS_REGS{1'b1}} << ARCH_COUNT;
  localparam logic [PRW:0]         RST_COUNT = (PRW+1)'(PHYS_REGS - ARCH_COUNT);

  logic [PHYS_REGS-1:0]  free_bits_q, free_bits_d;
  logic [PRW:0]          free_count_q, free_count_d;
  logic                  empty_q, empty_d;

  logic [N-1:0]          pick_vld;
  logic [N-1:0][PRW-1:0] pick_idx;
  logic [N-1:0]          grant;
  logic [N-1:0][PRW-1:0] tags;
  logic [PHYS_REGS-1:0]  granted_mask;

  free_list_picker #(.N(N), .PHYS_REGS(PHYS_REGS), .PRW(PRW)) u_picker (
    .bits_i     (free_bits_q),
    .pick_vld_o (pick_vld),
    .pick_idx_o (pick_idx)
  );

  // Walk lanes oldest (N-1) first; each requester takes the next slot, so a
  // denial propagates to every younger requester automatically.
  always_comb begin
    int slot;
    slot         = 0;
    grant        = '0;
    tags         = '0;
    granted_mask = '0;
    for (int l = N - 1; l >= 0; l--) begin
      if (fl.allocReq[l]) begin
        if (!reset && !fl.recoverEn && pick_vld[slot]) begin
          grant[l]     = 1'b1;
          tags[l]      = pick_idx[slot];
          granted_mask = granted_mask | (PHYS_REGS'(1) << pick_idx[slot]);
        end
        slot = slot + 1;
      end
    end
  end

  always_comb begin
    if (fl.recoverEn)
      free_bits_d = ~fl.archUsedMask | fl.freeMask;
    else
      free_bits_d = (free_bits_q & ~granted_mask) | fl.freeMask;
    free_bits_d[0] = 1'b0;
  end

  // Count is rebuilt from the next bitmap every cycle, never tracked incrementally.
  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < PHYS_REGS; i++)
      free_count_d = free_count_d + (PRW+1)'(free_bits_d[i]);
    empty_d = free_count_d < (PRW+1)'(N);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_bits_q  <= RST_FREE;
      free_count_q <= RST_COUNT;
      empty_q      <= 1'b0;
    end else begin
      free_bits_q  <= free_bits_d;
      free_count_q <= free_count_d;
      empty_q      <= empty_d;
    end
  end

  assign fl.allocGrant = grant;
  assign fl.allocTags  = tags;
  assign fl.freeCount  = free_count_q;
  assign fl.emptyFlag  = empty_q;
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with N=3, ARCH_COUNT=32, PHYS_REGS=64.
module tb_free_list;
  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  free_list_if #(.N(3), .PHYS_REGS(64), .PRW(6)) fl ();

  free_list #(.N(3), .ARCH_COUNT(32), .PHYS_REGS(64), .PRW(6)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and let combinational outputs settle for the new state.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_tags(input string tag, input logic [2:0] g,
                            input int t2, input int t1, input int t0);
    check({tag, ".grant"}, 64'(fl.allocGrant), 64'(g));
    if (g[2]) check({tag, ".lane2"}, 64'(fl.allocTags[2]), 64'(t2));
    if (g[1]) check({tag, ".lane1"}, 64'(fl.allocTags[1]), 64'(t1));
    if (g[0]) check({tag, ".lane0"}, 64'(fl.allocTags[0]), 64'(t0));
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    fl.allocReq     = 3'b111;
    fl.freeMask     = '0;
    fl.recoverEn    = 1'b0;
    fl.archUsedMask = '0;
    #1;
    check("rst.grant", 64'(fl.allocGrant), 64'd0);
    check("rst.tags", 64'(fl.allocTags), 64'd0);
    tick();
    reset       = 1'b0;
    fl.allocReq = '0;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst.count", 64'(fl.freeCount), 64'd32);
    check("rst.empty", 64'(fl.emptyFlag), 64'd0);

    // 1: full three-lane grant from reset state
    fl.allocReq = 3'b111; #1;
    check_tags("s1", 3'b111, 32, 33, 34);
    tick();
    check("s1.count", 64'(fl.freeCount), 64'd29);

    // 2: gap lane takes no slot
    fl.allocReq = '0;
    do_reset();
    fl.allocReq = 3'b101; #1;
    check_tags("s2a", 3'b101, 32, 0, 33);
    tick();
    fl.allocReq = 3'b111; #1;
    check_tags("s2b", 3'b111, 34, 35, 36);
    tick();
    check("s2.count", 64'(fl.freeCount), 64'd27);

    // 3: drain 37..60, then take 61 alone, leaving 62,63
    for (int i = 0; i < 8; i++) tick();
    check("s3.count3", 64'(fl.freeCount), 64'd3);
    check("s3.empty0", 64'(fl.emptyFlag), 64'd0);
    fl.allocReq = 3'b001; #1;
    check_tags("s3a", 3'b001, 0, 0, 61);
    tick();
    check("s3.count2", 64'(fl.freeCount), 64'd2);
    check("s3.empty1", 64'(fl.emptyFlag), 64'd1);
    fl.allocReq = 3'b111; #1;
    check_tags("s3b", 3'b110, 62, 63, 0);
    tick();
    check("s3.count0", 64'(fl.freeCount), 64'd0);

    // 4: freed PR is not bypassed to allocation
    fl.freeMask = 64'd1 << 40; #1;
    check_tags("s4a", 3'b000, 0, 0, 0);
    tick();
    fl.freeMask = '0; #1;
    check("s4.count", 64'(fl.freeCount), 64'd1);
    check_tags("s4b", 3'b100, 40, 0, 0);
    tick();
    check("s4.count0", 64'(fl.freeCount), 64'd0);

    // 5: recovery rebuild; PR45 stays in use
    fl.recoverEn    = 1'b1;
    fl.archUsedMask = 64'hFFFF_FFFF | (64'd1 << 45);
    #1;
    check_tags("s5a", 3'b000, 0, 0, 0);
    tick();
    fl.recoverEn = 1'b0; #1;
    check("s5.count", 64'(fl.freeCount), 64'd31);
    check("s5.empty", 64'(fl.emptyFlag), 64'd0);
    check_tags("s5b", 3'b111, 32, 33, 34);
    for (int i = 0; i < 4; i++) tick();
    check_tags("s5c", 3'b111, 44, 46, 47);
    tick();
    check("s5.count2", 64'(fl.freeCount), 64'd16);

    // 6: reset mid-stream with requests held and PR0 offered for free
    reset       = 1'b1;
    fl.freeMask = 64'd1;
    #1;
    check_tags("s6a", 3'b000, 0, 0, 0);
    tick();
    reset       = 1'b0;
    fl.allocReq = '0;
    tick();
    fl.freeMask = '0; #1;
    check("s6.count", 64'(fl.freeCount), 64'd32);
    check("s6.empty", 64'(fl.emptyFlag), 64'd0);
    fl.allocReq = 3'b111; #1;
    check_tags("s6b", 3'b111, 32, 33, 34);
    tick();
    check("s6.count2", 64'(fl.freeCount), 64'd29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
